// File: rtl/inlet_dose_pkg.sv
// Shared types and constants for the inlet dose sequencer and its pump stepper.
package inlet_dose_pkg;

  localparam int unsigned NUM_INLETS = 3;
  localparam int unsigned PUMP_W     = 3;
  localparam int unsigned NUM_PHASES = 6;
  localparam int unsigned PHASE_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    DOSE1,
    SETTLE1,
    DOSE2,
    SETTLE2,
    DOSE3,
    DONE
  } state_t;

  // Phase-valve drive pattern; index 0 is the first step of every dose.
  localparam logic [NUM_PHASES-1:0][PUMP_W-1:0] PUMP_PAT =
    {3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
    return (p == PHASE_W'(NUM_PHASES - 1)) ? '0 : p + PHASE_W'(1);
  endfunction

endpackage

// File: rtl/peristaltic_stepper.sv
// Step-rate divider and 6-phase pump pattern stepper for the peristaltic pump.
module peristaltic_stepper
  import inlet_dose_pkg::*;
#(
  parameter int unsigned DIV_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  step_div,
  output logic              tick,
  output logic [PUMP_W-1:0] pump
);

  logic [DIV_W-1:0]   div_cnt;
  logic [PHASE_W-1:0] phase;

  assign tick = enable && (div_cnt == step_div);

  // Restart wins so every new segment begins with a full step period at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= '0;
      pump    <= PUMP_PAT[0];
    end else if (restart) begin
      div_cnt <= '0;
      phase   <= '0;
      pump    <= PUMP_PAT[0];
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= next_phase(phase);
      pump    <= PUMP_PAT[next_phase(phase)];
    end else if (enable) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/inlet_dose_sequencer.sv
// Three-inlet dosing sequencer: opens one inlet at a time and runs the pump a
// programmed number of steps per inlet, with optional pump-off settle gaps.
module inlet_dose_sequencer
  import inlet_dose_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIV_W-1:0]      step_div,
  input  logic [CNT_W-1:0]      dose1,
  input  logic [CNT_W-1:0]      dose2,
  input  logic [CNT_W-1:0]      dose3,
  input  logic [CNT_W-1:0]      settle,
  output logic                  ready,
  output logic [NUM_INLETS-1:0] valve,
  output logic [PUMP_W-1:0]     pump,
  output logic                  done,
  output logic                  aborted
);

  state_t state, state_n;
  state_t after1, after2;

  logic                           hold, hold_n;
  logic [CNT_W-1:0]               cnt, cnt_n;
  logic [DIV_W-1:0]               div_q;
  logic [NUM_INLETS-1:0][CNT_W-1:0] dose_q;
  logic [CNT_W-1:0]               settle_q;
  logic [CNT_W-1:0]               cur_len;
  logic                           seg_end;
  logic                           latch;
  logic                           pump_on, pump_on_n;
  logic [NUM_INLETS-1:0]          valve_n;
  logic                           ready_n, done_n, aborted_n;
  logic                           tick, step_en, step_restart;
  logic [PUMP_W-1:0]              step_pump;

  peristaltic_stepper #(.DIV_W(DIV_W)) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (step_en),
    .restart  (step_restart),
    .step_div (div_q),
    .tick     (tick),
    .pump     (step_pump)
  );

  // Pump drive is gated by a registered enable so abort/reset force it off.
  assign pump = pump_on ? step_pump : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= 1'b0;
      cnt      <= '0;
      div_q    <= '0;
      dose_q   <= '0;
      settle_q <= '0;
      valve    <= '0;
      pump_on  <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      cnt     <= cnt_n;
      valve   <= valve_n;
      pump_on <= pump_on_n;
      ready   <= ready_n;
      done    <= done_n;
      aborted <= aborted_n;
      if (latch) begin
        div_q    <= step_div;
        dose_q   <= {dose3, dose2, dose1};
        settle_q <= settle;
      end
    end
  end

  always_comb begin
    state_n      = state;
    hold_n       = 1'b0;
    cnt_n        = cnt;
    latch        = 1'b0;
    aborted_n    = 1'b0;
    valve_n      = '0;
    pump_on_n    = 1'b0;
    cur_len      = '0;
    step_restart = 1'b0;

    // Zero-length doses are skipped by jumping straight to the next non-empty one.
    after1 = (dose_q[1] != '0) ? DOSE2 : ((dose_q[2] != '0) ? DOSE3 : DONE);
    after2 = (dose_q[2] != '0) ? DOSE3 : DONE;

    case (state)
      DOSE1:            cur_len = dose_q[0];
      DOSE2:            cur_len = dose_q[1];
      DOSE3:            cur_len = dose_q[2];
      SETTLE1, SETTLE2: cur_len = settle_q;
      default:          cur_len = '0;
    endcase

    step_en = (state != IDLE) && (state != DONE) && !hold;
    seg_end = (cur_len == '0) || (tick && (cnt == cur_len - CNT_W'(1)));

    case (state)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_n = DOSE1;
        end
      end
      DOSE1: begin
        if (seg_end) begin
          if (after1 == DONE) begin
            state_n = DONE;
          end else if ((dose_q[0] != '0) && (settle_q != '0)) begin
            state_n = SETTLE1;
          end else begin
            // Direct inlet change: insert one closed-valve cycle first.
            state_n = after1;
            hold_n  = (dose_q[0] != '0);
          end
        end
      end
      SETTLE1: if (seg_end) state_n = after1;
      DOSE2: begin
        if (seg_end) begin
          if (after2 == DONE) begin
            state_n = DONE;
          end else if (settle_q != '0) begin
            state_n = SETTLE2;
          end else begin
            state_n = after2;
            hold_n  = 1'b1;
          end
        end
      end
      SETTLE2: if (seg_end) state_n = after2;
      DOSE3:   if (seg_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      hold_n    = 1'b0;
      aborted_n = 1'b1;
    end

    step_restart = (state_n != state);

    if ((state_n != state) || hold) begin
      cnt_n = '0;
    end else if (tick) begin
      cnt_n = cnt + CNT_W'(1);
    end

    // Outputs are registered from the state being entered.
    case (state_n)
      DOSE1: begin
        if (latch ? (dose1 != '0) : (dose_q[0] != '0)) begin
          valve_n   = 3'b001;
          pump_on_n = 1'b1;
        end
      end
      DOSE2: begin
        if (!hold_n) begin
          valve_n   = 3'b010;
          pump_on_n = 1'b1;
        end
      end
      DOSE3: begin
        if (!hold_n) begin
          valve_n   = 3'b100;
          pump_on_n = 1'b1;
        end
      end
      default: begin
        valve_n   = '0;
        pump_on_n = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE);
    done_n  = (state_n == DONE);
  end

endmodule
